// File: rtl/servo_pkg.sv
// Constants and state encoding shared by the servo PWM generator and decoder.
package servo_pkg;

  localparam int DEF_PERIOD = 11;
  localparam int DEF_STEP   = 3;
  localparam int DEF_TOL    = 1;
  localparam int DEF_CW     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus delay flop; everything resets high so a line
// that is already high when reset releases never produces a rising edge.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      s    <= 1'b1;
      d    <= 1'b1;
    end else begin
      meta <= din;
      s    <= meta;
      d    <= s;
    end
  end

  assign rise = s & ~d;
  assign fall = ~s & d;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Recovers the 2-bit servo angle code from a sampled PWM line and flags
// malformed frames (ERR pulse) and a stuck-high line (LOST level).
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int STEP   = DEF_STEP,
  parameter int TOL    = DEF_TOL,
  parameter int CW     = DEF_CW
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       PWM_IN,
  output logic [1:0] ANG,
  output logic       VALID,
  output logic       ERR,
  output logic       LOST
);

  localparam logic [CW-1:0] P_NOM = CW'(PERIOD);
  localparam logic [CW-1:0] P_LO  = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] P_HI  = CW'(PERIOD + TOL);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + C_ONE;
  endfunction

  logic s, rise, fall;

  sync_edge u_sync (
    .clk   (CLK),
    .reset (reset),
    .din   (PWM_IN),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  state_t        state;
  logic [CW-1:0] hcnt, pcnt, lcnt;
  logic [CW-1:0] hcnt_n, pcnt_n, lcnt_n;
  logic          frame_ok;
  logic          dec_ok;
  logic [1:0]    dec_ang;
  int            h;

  assign hcnt_n   = sat_inc(hcnt);
  assign pcnt_n   = sat_inc(pcnt);
  assign lcnt_n   = sat_inc(lcnt);
  assign frame_ok = (pcnt >= P_LO) && (pcnt <= P_HI);

  // Nearest code within TOL of k*STEP; 2*TOL < STEP keeps the match unique.
  always_comb begin
    dec_ok  = 1'b0;
    dec_ang = 2'd0;
    h       = int'(hcnt);
    for (int k = 3; k >= 0; k--) begin
      if ((h + TOL >= k * STEP) && (h <= k * STEP + TOL)) begin
        dec_ok  = 1'b1;
        dec_ang = 2'(k);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      hcnt  <= '0;
      pcnt  <= '0;
      lcnt  <= '0;
      ANG   <= 2'd0;
      VALID <= 1'b0;
      ERR   <= 1'b0;
      LOST  <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= HIGH;
            hcnt  <= C_ONE;
            pcnt  <= C_ONE;
          end else if (!s) begin
            // A full period of low line is a legitimate ANG=0 frame.
            if (lcnt_n == P_NOM) begin
              VALID <= 1'b1;
              ANG   <= 2'd0;
              lcnt  <= '0;
            end else begin
              lcnt <= lcnt_n;
            end
          end
        end
        HIGH: begin
          if (fall) begin
            state <= LOW;
            pcnt  <= pcnt_n;
          end else begin
            hcnt <= hcnt_n;
            pcnt <= pcnt_n;
            if (hcnt_n >= P_NOM) begin
              ERR   <= 1'b1;
              LOST  <= 1'b1;
              state <= STUCK;
            end
          end
        end
        LOW: begin
          if (rise) begin
            if (frame_ok && dec_ok) begin
              VALID <= 1'b1;
              ANG   <= dec_ang;
            end else begin
              ERR <= 1'b1;
            end
            state <= HIGH;
            hcnt  <= C_ONE;
            pcnt  <= C_ONE;
          end else if (pcnt_n > P_HI) begin
            // Line went quiet: judge the last frame on its high time alone.
            if (dec_ok) begin
              VALID <= 1'b1;
              ANG   <= dec_ang;
            end else begin
              ERR <= 1'b1;
            end
            lcnt  <= '0;
            state <= IDLE;
          end else begin
            pcnt <= pcnt_n;
          end
        end
        STUCK: begin
          if (fall) begin
            LOST  <= 1'b0;
            lcnt  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
